correlate_sched: RTL and testbench
==================================

Name: correlate_sched

Overview:
- Frame-level sequencer for the stereo correlation pipeline.
- Walks the image row by row:
  - flushes the correlator before each row;
  - streams each row's census bitvecs into it as one gap-free burst (the correlator shift buffer advances every cycle, so any gap corrupts the window);
  - counts returned disparities and writes them, with their pixel address, into the disparity frame memory.
- Sits between the census line buffers, the correlator and the disparity memory writer.

Parameters:
- IMG_W, 640, pixels per row; must be > DISP.
- IMG_H, 480, rows per frame.
- DISP, 64, correlator disparity count; the first DISP-1 pixels of each row produce no output.
- RD_LAT, 1, census line-buffer read latency in cycles (>=1).
- DRAIN_TMO, 32, maximum cycles spent in DRAIN before a timeout is flagged.
- AW, 19, disparity memory address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse that starts a frame; ignored while busy
- row_avail  in  1  level: census rows for the current rd_y are readable
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse at frame end
- rd_en  out  1  census read strobe
- rd_x  out  10  census read column
- rd_y  out  10  census read row
- corr_flush  out  1  drives the correlator reset input
- corr_bitvec_val  out  1  rd_en delayed by RD_LAT cycles
- corr_pixel_x  out  10  rd_x delayed by RD_LAT cycles
- corr_pixel_y  out  10  rd_y delayed by RD_LAT cycles
- corr_disp_val  in  1  correlator disparity_val
- corr_disp  in  $clog2(DISP)  correlator disparity
- dm_we  out  1  disparity memory write enable
- dm_addr  out  AW  disparity memory write address
- dm_data  out  $clog2(DISP)  disparity memory write data
- err_timeout  out  1  sticky: a row drained short
- err_overrun  out  1  sticky: an unexpected corr_disp_val was received

Behaviour:
- Reset: clk, reset per the already-decided item (synchronous, active-high). reset forces state=IDLE and drives every output to 0, including both sticky error flags and the delay pipes. Reset mid-frame abandons the frame; frame_done is not asserted.
- States: IDLE, FLUSH, WAIT_ROW, FEED, DRAIN, DONE.
- IDLE:
  - frame_start -> FLUSH; sets y=0 and clears err_timeout and err_overrun.
- FLUSH (1 cycle):
  - corr_flush=1; ocount=0 -> WAIT_ROW.
- WAIT_ROW:
  - rd_en=0; row_avail=1 -> FEED with x=0.
- FEED (exactly IMG_W cycles):
  - rd_en=1, rd_x=x, rd_y=y; x increments each cycle.
  - row_avail is not sampled, so the burst is never broken.
  - After the cycle with x=IMG_W-1 -> DRAIN with tmo=0.
- DRAIN:
  - Leaves when ocount == IMG_W-DISP+1.
  - Also leaves when tmo == DRAIN_TMO; in that case set err_timeout.
  - Exit goes to DONE if y == IMG_H-1, else increments y and goes to FLUSH.
- DONE:
  - frame_done=1 for one cycle -> IDLE.
- Write path:
  - Registered, 1 cycle after corr_disp_val.
  - A write occurs when corr_disp_val=1, state is FEED or DRAIN, and ocount < IMG_W-DISP+1.
  - On a write: dm_we=1, dm_addr = y*IMG_W + (DISP-1) + ocount, dm_data = corr_disp; ocount increments.
  - Row base y*IMG_W is kept as an accumulator that adds IMG_W per row (no multiplier).
  - In any other state, or with ocount saturated, corr_disp_val sets err_overrun and no write occurs.
- tmo counts DRAIN cycles only; tmo resets on entry to DRAIN.
- Delay pipes: corr_bitvec_val, corr_pixel_x and corr_pixel_y are shift registers of depth RD_LAT, cleared on reset.
- corr_flush: must not assert while any corr_bitvec_val is still in the delay pipe. This is guaranteed because FLUSH follows DRAIN, and DRAIN lasts >= RD_LAT cycles in normal operation.
- frame_start during busy: ignored, with no effect on state or errors.
- row_avail: may drop at any time; it is only sampled in WAIT_ROW.

Test Plan:
- Bench uses a correlator model with latency 8 after corr_bitvec_val, IMG_W=80, IMG_H=3, DISP=8, RD_LAT=2.
  - Full frame -> exactly 73 writes per row, addresses 7..79 / 87..159 / 167..239, frame_done once.
  - Expected cycle count checked.
- row_avail held low 20 cycles before row 1 -> WAIT_ROW holds, rd_en=0, no corr_flush repeat.
  - FEED burst is then 80 contiguous rd_en cycles.
- Model drops the last 2 disparities of row 0 -> err_timeout=1 after DRAIN_TMO cycles.
  - Row 1 still starts and is written at base 80; err_timeout is cleared by the next frame_start.
- Inject corr_disp_val while IDLE -> err_overrun=1, dm_we stays 0.
- frame_start pulsed mid-FEED -> ignored; reset asserted mid-FEED -> next cycle busy=0, rd_en=0, dm_we=0, all outputs 0, and no frame_done.
- Back-to-back frame_start in the cycle after frame_done -> second frame starts at y=0 with corr_flush.

Source files
------------

// File: rtl/correlate_sched.sv
// correlate_sched: frame sequencer feeding census rows to the stereo correlator and writing disparities to frame memory.
// Latency: FLUSH, WAIT_ROW, IMG_W FEED cycles, then DRAIN until all row outputs return; memory writes are 1 cycle after corr_disp_val.
// Backpressure: none inside a row; the burst is gap-free and row_avail gates only the start of each row.
// Ports: clk/reset (sync, active-high); frame_start/busy/frame_done frame control; row_avail, rd_en/rd_x/rd_y census read;
//        corr_flush, corr_bitvec_val, corr_pixel_x/y to the correlator; corr_disp_val/corr_disp from it;
//        dm_we/dm_addr/dm_data disparity memory write; err_timeout, err_overrun sticky error flags.
module correlate_sched #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int DISP      = 64,
    parameter int RD_LAT    = 1,
    parameter int DRAIN_TMO = 32,
    parameter int AW        = 19,
    localparam int DW       = $clog2(DISP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          row_avail,
    output logic          busy,
    output logic          frame_done,
    output logic          rd_en,
    output logic [9:0]    rd_x,
    output logic [9:0]    rd_y,
    output logic          corr_flush,
    output logic          corr_bitvec_val,
    output logic [9:0]    corr_pixel_x,
    output logic [9:0]    corr_pixel_y,
    input  logic          corr_disp_val,
    input  logic [DW-1:0] corr_disp,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_data,
    output logic          err_timeout,
    output logic          err_overrun
);

    // Outputs per row: the first DISP-1 pixels of a row produce nothing.
    localparam int NOUT = IMG_W - DISP + 1;
    localparam int OCW  = $clog2(NOUT + 1);
    localparam int TW   = $clog2(DRAIN_TMO + 1);

    localparam logic [9:0]    LAST_X   = 10'(IMG_W - 1);
    localparam logic [9:0]    LAST_Y   = 10'(IMG_H - 1);
    localparam logic [OCW-1:0] NOUT_C  = OCW'(NOUT);
    localparam logic [TW-1:0] TMO_C    = TW'(DRAIN_TMO);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] X_OFS    = AW'(DISP - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_ROW,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    logic [OCW-1:0] ocount;
    logic [TW-1:0]  tmo;
    logic [AW-1:0]  row_base;   // y*IMG_W, accumulated one row at a time

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            rd_en       <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            corr_flush  <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_data     <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            ocount      <= '0;
            tmo         <= '0;
            row_base    <= '0;
        end else begin
            frame_done <= 1'b0;
            corr_flush <= 1'b0;
            dm_we      <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= FLUSH;
                        busy        <= 1'b1;
                        corr_flush  <= 1'b1;
                        rd_y        <= '0;
                        row_base    <= '0;
                        err_timeout <= 1'b0;
                        err_overrun <= 1'b0;
                    end
                end
                FLUSH: begin
                    ocount <= '0;
                    state  <= WAIT_ROW;
                end
                WAIT_ROW: begin
                    if (row_avail) begin
                        state <= FEED;
                        rd_en <= 1'b1;
                        rd_x  <= '0;
                    end
                end
                FEED: begin
                    // row_avail deliberately ignored: a gap would corrupt the correlator window
                    if (rd_x == LAST_X) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        tmo   <= '0;
                    end else begin
                        rd_x <= rd_x + 10'd1;
                    end
                end
                DRAIN: begin
                    if (ocount == NOUT_C || tmo == TMO_C) begin
                        if (ocount != NOUT_C) begin
                            err_timeout <= 1'b1;
                        end
                        if (rd_y == LAST_Y) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state      <= FLUSH;
                            corr_flush <= 1'b1;
                            rd_y       <= rd_y + 10'd1;
                            row_base   <= row_base + ROW_STEP;
                        end
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase

            // Write path; placed after the case so a stray disparity in IDLE wins over the frame_start clear.
            if (corr_disp_val) begin
                if ((state == FEED || state == DRAIN) && ocount < NOUT_C) begin
                    dm_we   <= 1'b1;
                    dm_addr <= row_base + X_OFS + AW'(ocount);
                    dm_data <= corr_disp;
                    ocount  <= ocount + OCW'(1);
                end else begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

    // Align read strobe and pixel coordinates with the census data returning RD_LAT cycles later.
    logic [RD_LAT-1:0] val_pipe;
    logic [9:0]        px_pipe [RD_LAT];
    logic [9:0]        py_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            val_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                px_pipe[i] <= '0;
                py_pipe[i] <= '0;
            end
        end else begin
            val_pipe[0] <= rd_en;
            px_pipe[0]  <= rd_x;
            py_pipe[0]  <= rd_y;
            for (int i = 1; i < RD_LAT; i++) begin
                val_pipe[i] <= val_pipe[i-1];
                px_pipe[i]  <= px_pipe[i-1];
                py_pipe[i]  <= py_pipe[i-1];
            end
        end
    end

    assign corr_bitvec_val = val_pipe[RD_LAT-1];
    assign corr_pixel_x    = px_pipe[RD_LAT-1];
    assign corr_pixel_y    = py_pipe[RD_LAT-1];

endmodule

// File: tb/tb_correlate_sched.sv
// tb_correlate_sched: drives correlate_sched with a latency-8 correlator model and checks writes, timing and error flags.
// Latency: stimulus and checks run once per cycle on the falling edge.
// Backpressure: row_avail driven by each scenario (constant, held low, or random).
module tb_correlate_sched;

    localparam int IMG_W     = 80;
    localparam int IMG_H     = 3;
    localparam int DISP      = 8;
    localparam int RD_LAT    = 2;
    localparam int DRAIN_TMO = 32;
    localparam int AW        = 19;
    localparam int DW        = 3;
    localparam int CLAT      = 8;
    localparam int NOUT      = IMG_W - DISP + 1;
    // A row: FLUSH + WAIT_ROW + IMG_W feed cycles + drain until the last disparity is written.
    localparam int DRAIN_LEN = RD_LAT + CLAT + 1;
    localparam int ROW_CYC   = 2 + IMG_W + DRAIN_LEN;

    logic          clk = 1'b0;
    logic          reset, frame_start, row_avail;
    logic          busy, frame_done, rd_en, corr_flush, corr_bitvec_val;
    logic [9:0]    rd_x, rd_y, corr_pixel_x, corr_pixel_y;
    logic          corr_disp_val;
    logic [DW-1:0] corr_disp;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data;
    logic          err_timeout, err_overrun;

    correlate_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DISP(DISP), .RD_LAT(RD_LAT),
        .DRAIN_TMO(DRAIN_TMO), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .row_avail(row_avail),
        .busy(busy), .frame_done(frame_done), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .corr_flush(corr_flush), .corr_bitvec_val(corr_bitvec_val),
        .corr_pixel_x(corr_pixel_x), .corr_pixel_y(corr_pixel_y),
        .corr_disp_val(corr_disp_val), .corr_disp(corr_disp),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct { bit v; int addr; int d; } slot_t;
    typedef struct { int addr; int d; } wr_t;

    slot_t line [CLAT];
    wr_t   exp_q [$];
    int    vectors = 0, miscompares = 0;
    int    inject = 0, drop_row0 = 0, rand_avail = 0;
    int    run = 0, rows_fed = 0, fd_cnt = 0, flush_cnt = 0;
    int    wr_cnt [IMG_H];
    int    first_a [IMG_H];
    int    last_a [IMG_H];

    task automatic clear_stats();
        for (int r = 0; r < IMG_H; r++) begin
            wr_cnt[r] = 0; first_a[r] = -1; last_a[r] = -1;
        end
        fd_cnt = 0; flush_cnt = 0; rows_fed = 0;
    endtask

    // One cycle: observe DUT outputs, then advance the correlator model and drive its outputs.
    task automatic tick();
        slot_t o;
        wr_t   w;
        int    r;
        @(negedge clk);
        if (reset) begin
            run = 0;
        end else begin
            if (dm_we === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write addr=%0d data=%0d (no disparity pending)", dm_addr, dm_data);
                end else begin
                    w = exp_q.pop_front();
                    if (int'(dm_addr) !== w.addr || int'(dm_data) !== w.d) begin
                        miscompares++;
                        $display("FAIL write addr/data got %0d/%0d expected %0d/%0d", dm_addr, dm_data, w.addr, w.d);
                    end
                end
                r = int'(dm_addr) / IMG_W;
                if (r < IMG_H) begin
                    wr_cnt[r]++;
                    if (first_a[r] < 0) first_a[r] = int'(dm_addr);
                    last_a[r] = int'(dm_addr);
                end
            end
            if (rd_en === 1'b1) begin
                vectors++;
                if (int'(rd_x) !== run || int'(rd_y) !== rows_fed) begin
                    miscompares++;
                    $display("FAIL rd_coord got x=%0d y=%0d expected x=%0d y=%0d", rd_x, rd_y, run, rows_fed);
                end
                run++;
            end else if (run != 0) begin
                vectors++;
                if (run != IMG_W) begin
                    miscompares++;
                    $display("FAIL burst_len got %0d expected %0d", run, IMG_W);
                end
                run = 0;
                rows_fed++;
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (corr_flush === 1'b1) begin
                flush_cnt++;
                vectors++;
                if (corr_bitvec_val !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_overlap corr_bitvec_val=%b expected 0 during corr_flush", corr_bitvec_val);
                end
            end
        end
        // Correlator: pixel x produces a disparity CLAT cycles after its bitvec once x >= DISP-1.
        o = line[CLAT-1];
        for (int i = CLAT - 1; i > 0; i--) line[i] = line[i-1];
        line[0].v = !reset && (corr_bitvec_val === 1'b1) && int'(corr_pixel_x) >= DISP - 1 &&
                    !(drop_row0 != 0 && int'(corr_pixel_y) == 0 && int'(corr_pixel_x) >= IMG_W - 2);
        line[0].addr = int'(corr_pixel_y) * IMG_W + int'(corr_pixel_x);
        line[0].d = int'($urandom_range(0, DISP - 1));
        if (reset) begin
            for (int i = 0; i < CLAT; i++) line[i].v = 1'b0;
            o.v = 1'b0;
            exp_q.delete();
        end
        corr_disp_val = o.v || (inject != 0);
        corr_disp = o.v ? DW'(o.d) : '0;
        if (o.v) begin
            w.addr = o.addr; w.d = o.d;
            exp_q.push_back(w);
        end
        if (rand_avail != 0) row_avail = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_frame_done no frame_done within %0d cycles", max);
        end
    endtask

    task automatic wait_rd_en(input int max);
        int n = 0;
        while (rd_en !== 1'b1 && n < max) begin tick(); n++; end
        vectors++;
        if (rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_rd_en rd_en=%b expected 1 within %0d cycles", rd_en, max);
        end
    endtask

    task automatic wait_flush(input int max);
        int n = 0;
        while (corr_flush !== 1'b1 && n < max) begin tick(); n++; end
        vectors++;
        if (corr_flush !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_flush corr_flush=%b expected 1 within %0d cycles", corr_flush, max);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        vectors++;
        if ({frame_done, rd_en, corr_flush, corr_bitvec_val, dm_we, err_timeout, err_overrun} !== 7'h0) begin
            miscompares++;
            $display("FAIL reset_flags got %b expected 0000000",
                     {frame_done, rd_en, corr_flush, corr_bitvec_val, dm_we, err_timeout, err_overrun});
        end
        vectors++;
        if ({rd_x, rd_y, corr_pixel_x, corr_pixel_y, dm_addr, dm_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses got rd_x=%0d rd_y=%0d px=%0d py=%0d addr=%0d data=%0d expected all 0",
                     rd_x, rd_y, corr_pixel_x, corr_pixel_y, dm_addr, dm_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic check_rows(input string tag, input int row0_cnt);
        for (int r = 0; r < IMG_H; r++) begin
            int want = (r == 0) ? row0_cnt : NOUT;
            vectors++;
            if (wr_cnt[r] != want || first_a[r] != r * IMG_W + DISP - 1 ||
                last_a[r] != r * IMG_W + DISP - 1 + want - 1) begin
                miscompares++;
                $display("FAIL %s row%0d got cnt=%0d first=%0d last=%0d expected cnt=%0d first=%0d last=%0d",
                         tag, r, wr_cnt[r], first_a[r], last_a[r], want, r * IMG_W + DISP - 1,
                         r * IMG_W + DISP - 1 + want - 1);
            end
        end
    endtask

    task automatic test_full_frame();
        int n;
        row_avail = 1'b1;
        clear_stats();
        pulse_start();
        vectors++;
        if (corr_flush !== 1'b1 || busy !== 1'b1 || rd_y !== 10'd0) begin
            miscompares++;
            $display("FAIL start_flush got flush=%b busy=%b y=%0d expected 1 1 0", corr_flush, busy, rd_y);
        end
        wait_done(2000, n);
        vectors++;
        if (n != IMG_H * ROW_CYC) begin
            miscompares++;
            $display("FAIL frame_cycles got %0d expected %0d", n, IMG_H * ROW_CYC);
        end
        repeat (5) tick();
        vectors++;
        if (fd_cnt != 1 || busy !== 1'b0 || flush_cnt != IMG_H) begin
            miscompares++;
            $display("FAIL frame_end got done_pulses=%0d busy=%b flushes=%0d expected 1 0 %0d", fd_cnt, busy, flush_cnt, IMG_H);
        end
        check_rows("full_frame", NOUT);
        vectors++;
        if (exp_q.size() != 0 || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL full_frame_tail got pending=%0d tmo=%b ovr=%b expected 0 0 0", exp_q.size(), err_timeout, err_overrun);
        end
    endtask

    task automatic test_overrun();
        inject = 1;
        tick();
        inject = 0;
        tick();
        vectors++;
        if (err_overrun !== 1'b1 || dm_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_overrun got ovr=%b we=%b busy=%b expected 1 0 0", err_overrun, dm_we, busy);
        end
        repeat (3) tick();
        vectors++;
        if (err_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky got %b expected 1", err_overrun);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        rand_avail = 1;
        clear_stats();
        pulse_start();
        vectors++;
        if (err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got %b expected 0", err_overrun);
        end
        wait_done(5000, n);
        check_rows("rand_avail", NOUT);
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done_busy got %b expected 0", busy);
        end
        clear_stats();
        pulse_start();
        vectors++;
        if (corr_flush !== 1'b1 || busy !== 1'b1 || rd_y !== 10'd0) begin
            miscompares++;
            $display("FAIL back_to_back_start got flush=%b busy=%b y=%0d expected 1 1 0", corr_flush, busy, rd_y);
        end
        wait_done(5000, n);
        check_rows("back_to_back", NOUT);
        rand_avail = 0;
        repeat (3) tick();
    endtask

    task automatic test_row_avail();
        int n, f0, en_seen;
        row_avail = 1'b1;
        clear_stats();
        pulse_start();
        wait_rd_en(50);
        row_avail = 1'b0;
        wait_flush(500);
        f0 = flush_cnt;
        en_seen = 0;
        repeat (20) begin
            tick();
            if (rd_en === 1'b1) en_seen++;
        end
        vectors++;
        if (en_seen != 0 || flush_cnt != f0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_row_hold got rd_en_cycles=%0d extra_flushes=%0d busy=%b expected 0 0 1",
                     en_seen, flush_cnt - f0, busy);
        end
        row_avail = 1'b1;
        wait_done(2000, n);
        repeat (2) tick();
        vectors++;
        if (rows_fed != IMG_H) begin
            miscompares++;
            $display("FAIL rows_fed got %0d expected %0d", rows_fed, IMG_H);
        end
        check_rows("row_avail", NOUT);
    endtask

    task automatic test_drop_timeout();
        int n;
        drop_row0 = 1;
        row_avail = 1'b1;
        clear_stats();
        pulse_start();
        wait_done(3000, n);
        drop_row0 = 0;
        vectors++;
        if (n != IMG_H * ROW_CYC + (DRAIN_TMO + 1) - DRAIN_LEN) begin
            miscompares++;
            $display("FAIL timeout_cycles got %0d expected %0d", n, IMG_H * ROW_CYC + (DRAIN_TMO + 1) - DRAIN_LEN);
        end
        vectors++;
        if (err_timeout !== 1'b1 || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flag got tmo=%b ovr=%b expected 1 0", err_timeout, err_overrun);
        end
        check_rows("drop_row0", NOUT - 2);
        repeat (3) tick();
        clear_stats();
        pulse_start();
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got %b expected 0", err_timeout);
        end
        wait_done(2000, n);
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clean_frame got %b expected 0", err_timeout);
        end
        repeat (3) tick();
    endtask

    task automatic test_mid_feed();
        int x0, fd0;
        row_avail = 1'b1;
        clear_stats();
        pulse_start();
        wait_rd_en(50);
        repeat (10) tick();
        x0 = int'(rd_x);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || corr_flush !== 1'b0 || int'(rd_x) != x0 + 2 || rd_y !== 10'd0) begin
            miscompares++;
            $display("FAIL start_ignored got busy=%b en=%b flush=%b x=%0d y=%0d expected 1 1 0 %0d 0",
                     busy, rd_en, corr_flush, rd_x, rd_y, x0 + 2);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({busy, frame_done, rd_en, corr_flush, corr_bitvec_val, dm_we, err_timeout, err_overrun,
             rd_x, rd_y, corr_pixel_x, corr_pixel_y, dm_addr, dm_data} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b en=%b we=%b x=%0d y=%0d addr=%0d expected all 0",
                     busy, rd_en, dm_we, rd_x, rd_y, dm_addr);
        end
        reset = 1'b0;
        fd0 = fd_cnt;
        repeat (150) tick();
        vectors++;
        if (fd_cnt != fd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_frame got done_pulses=%0d busy=%b expected 0 0", fd_cnt - fd0, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        row_avail = 1'b0;
        corr_disp_val = 1'b0;
        corr_disp = '0;
        for (int i = 0; i < CLAT; i++) begin
            line[i].v = 1'b0; line[i].addr = 0; line[i].d = 0;
        end
        clear_stats();
        test_reset();
        test_full_frame();
        test_overrun();
        test_back_to_back();
        test_row_avail();
        test_drop_timeout();
        test_mid_feed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
